// File: rtl/proc_control_unit_if.sv
// -----------------------------------------------------------------------------
// proc_control_unit_if
//
// Bundles every non-clock, non-reset signal between the processor control
// unit and the datapath/memory side so they travel as one port.
//
// Signals (direction as seen from the control unit, modport master):
//   run          in   1  level; keep fetching/executing while high
//   instr_op     in   4  opcode field instruction[19:16] from the IR
//   mem_ready    in   1  completion strobe for the outstanding mem_req
//   cond_zero    in   1  ALU result register equals zero
//   mem_req      out  1  memory request
//   W            out  1  memory write strobe (store only)
//   ir_we        out  1  instruction register load
//   pc_inc       out  1  program counter increment
//   rf_we        out  1  register file write
//   alu_we       out  1  ALU result register load
//   addr_we      out  1  memory address register load
//   dout_we      out  1  memory data-out register load
//   alu_op       out  2  00 add, 01 or, 10 and, 11 not
//   mux_sel      out  3  000 Rb, 001 Ra, 010 DataIn, 011 ALU reg, 100 PC
//   rd1_src      out  1  0: rd port 1 <- instr[11:8], 1: instr[15:12]
//   state        out  3  current FSM state encoding
//   instr_done   out  1  one-cycle retire pulse
//   err_illegal  out  1  sticky illegal-opcode flag
//   err_timeout  out  1  sticky memory-timeout flag
//   retired      out 16  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
interface proc_control_unit_if;
  logic        run;
  logic [3:0]  instr_op;
  logic        mem_ready;
  logic        cond_zero;

  logic        mem_req;
  logic        W;
  logic        ir_we;
  logic        pc_inc;
  logic        rf_we;
  logic        alu_we;
  logic        addr_we;
  logic        dout_we;
  logic [1:0]  alu_op;
  logic [2:0]  mux_sel;
  logic        rd1_src;
  logic [2:0]  state;
  logic        instr_done;
  logic        err_illegal;
  logic        err_timeout;
  logic [15:0] retired;

  // Control unit side: consumes status, drives controls
  modport master (
    input  run, instr_op, mem_ready, cond_zero,
    output mem_req, W, ir_we, pc_inc, rf_we, alu_we, addr_we, dout_we,
           alu_op, mux_sel, rd1_src, state, instr_done,
           err_illegal, err_timeout, retired
  );

  // Datapath / memory / environment side
  modport slave (
    output run, instr_op, mem_ready, cond_zero,
    input  mem_req, W, ir_we, pc_inc, rf_we, alu_we, addr_we, dout_we,
           alu_op, mux_sel, rd1_src, state, instr_done,
           err_illegal, err_timeout, retired
  );
endinterface

// File: rtl/proc_control_unit.sv
// -----------------------------------------------------------------------------
// proc_control_unit
//
// Multi-cycle control FSM for a small load/store processor. Sequences
// instruction fetch, decode, ALU execute, register write-back and memory
// load/store, with a bounded wait on the memory handshake, sticky error
// flags and a retired-instruction counter.
//
// Parameters:
//   WAIT_MAX  maximum number of mem_ready wait cycles before timeout (1..255)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    proc_control_unit_if.master (see interface file for signal list)
//
// Opcodes: 0000-0011 ALU (add/or/and/not), 1101 load, 1100 store,
//          1110 copy, 1111 copy input, 1011 copy if result non-zero;
//          everything else is illegal and retires as a no-op.
// -----------------------------------------------------------------------------
module proc_control_unit #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  proc_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    SDATA  = 3'd4,
    MEM    = 3'd5,
    WB     = 3'd6
  } state_t;

  localparam logic [3:0] OP_CCOPY   = 4'b1011;
  localparam logic [3:0] OP_STORE   = 4'b1100;
  localparam logic [3:0] OP_LOAD    = 4'b1101;
  localparam logic [3:0] OP_COPY    = 4'b1110;
  localparam logic [3:0] OP_COPY_IN = 4'b1111;

  localparam logic [2:0] SEL_RB   = 3'b000;
  localparam logic [2:0] SEL_RA   = 3'b001;
  localparam logic [2:0] SEL_DIN  = 3'b010;
  localparam logic [2:0] SEL_ALU  = 3'b011;
  localparam logic [2:0] SEL_PC   = 3'b100;

  // The timeout fires on the wait cycle that would bring the counter to
  // WAIT_MAX, so the request is held for exactly WAIT_MAX cycles.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt;
  logic [15:0] retired_q;
  logic        err_illegal_q;
  logic        err_timeout_q;
  logic [3:0]  op_q;

  logic dec_alu;
  logic dec_load;
  logic dec_store;
  logic dec_copy;
  logic dec_illegal;

  logic       mem_req;
  logic       write_strobe;
  logic       ir_we;
  logic       pc_inc;
  logic       rf_we;
  logic       alu_we;
  logic       addr_we;
  logic       dout_we;
  logic [1:0] alu_op;
  logic [2:0] mux_sel;
  logic       rd1_src;
  logic       complete;
  logic       timeout;

  // Opcode classification of the live IR field, used only during DECODE.
  always_comb begin
    dec_alu     = (bus.instr_op[3:2] == 2'b00);
    dec_load    = (bus.instr_op == OP_LOAD);
    dec_store   = (bus.instr_op == OP_STORE);
    dec_copy    = (bus.instr_op == OP_COPY) || (bus.instr_op == OP_COPY_IN) ||
                  (bus.instr_op == OP_CCOPY);
    dec_illegal = !(dec_alu || dec_load || dec_store || dec_copy);
  end

  // Control decode. Enables that react to mem_ready or cond_zero must do so
  // in the same cycle to meet the minimum instruction latencies, so they are
  // decoded from the registered state plus the live handshake inputs.
  always_comb begin
    mem_req      = 1'b0;
    write_strobe = 1'b0;
    ir_we        = 1'b0;
    pc_inc       = 1'b0;
    rf_we        = 1'b0;
    alu_we       = 1'b0;
    addr_we      = 1'b0;
    dout_we      = 1'b0;
    alu_op       = 2'b00;
    mux_sel      = SEL_PC;
    rd1_src      = 1'b0;
    complete     = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        // wait_cnt only moves while stalled, so zero marks the first cycle
        addr_we = (wait_cnt == 8'd0);
        if (bus.mem_ready) begin
          ir_we  = 1'b1;
          pc_inc = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
        end
      end

      DECODE: begin
        if (dec_load) begin
          addr_we = 1'b1;
          mux_sel = SEL_RA;
        end else if (dec_store) begin
          rd1_src = 1'b1;
          addr_we = 1'b1;
          mux_sel = SEL_RB;
        end else if (dec_illegal) begin
          complete = 1'b1;
        end
      end

      EXEC: begin
        alu_we = 1'b1;
        alu_op = op_q[1:0];
      end

      SDATA: begin
        rd1_src = 1'b1;
        mux_sel = SEL_RA;
        dout_we = 1'b1;
      end

      MEM: begin
        mem_req = 1'b1;
        if (op_q == OP_STORE) begin
          write_strobe = 1'b1;
          rd1_src      = 1'b1;
        end
        if (bus.mem_ready) begin
          complete = 1'b1;
          if (op_q == OP_LOAD) begin
            rf_we   = 1'b1;
            mux_sel = SEL_DIN;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
        end
      end

      WB: begin
        complete = 1'b1;
        case (op_q)
          OP_COPY: begin
            rf_we   = 1'b1;
            mux_sel = SEL_RA;
          end
          OP_COPY_IN: begin
            rf_we   = 1'b1;
            mux_sel = SEL_DIN;
          end
          OP_CCOPY: begin
            rf_we   = !bus.cond_zero;
            mux_sel = SEL_RA;
          end
          default: begin
            rf_we   = 1'b1;
            mux_sel = SEL_ALU;
          end
        endcase
      end

      default: ;
    endcase
  end

  // Sequencer state, wait counter, retire counter and sticky error flags.
  // Timeout and completion are applied after the per-state transitions so
  // they take precedence over the default next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_cnt      <= 8'd0;
      retired_q     <= 16'd0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      op_q          <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q  <= FETCH;
            wait_cnt <= 8'd0;
          end
        end

        FETCH: begin
          if (bus.mem_ready) begin
            state_q <= DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DECODE: begin
          op_q <= bus.instr_op;
          if (dec_alu) begin
            state_q <= EXEC;
          end else if (dec_load) begin
            state_q  <= MEM;
            wait_cnt <= 8'd0;
          end else if (dec_store) begin
            state_q <= SDATA;
          end else if (dec_copy) begin
            state_q <= WB;
          end else begin
            err_illegal_q <= 1'b1;
          end
        end

        EXEC:  state_q <= WB;

        SDATA: begin
          state_q  <= MEM;
          wait_cnt <= 8'd0;
        end

        MEM: begin
          if (!bus.mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        WB: ;

        default: state_q <= IDLE;
      endcase

      if (timeout) begin
        err_timeout_q <= 1'b1;
        state_q       <= IDLE;
      end

      if (complete) begin
        retired_q <= retired_q + 16'd1;
        wait_cnt  <= 8'd0;
        state_q   <= bus.run ? FETCH : IDLE;
      end
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.W           = write_strobe;
  assign bus.ir_we       = ir_we;
  assign bus.pc_inc      = pc_inc;
  assign bus.rf_we       = rf_we;
  assign bus.alu_we      = alu_we;
  assign bus.addr_we     = addr_we;
  assign bus.dout_we     = dout_we;
  assign bus.alu_op      = alu_op;
  assign bus.mux_sel     = mux_sel;
  assign bus.rd1_src     = rd1_src;
  assign bus.state       = state_q;
  assign bus.instr_done  = complete;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.retired     = retired_q;

endmodule

// File: doc/proc_control_unit.md
PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

Interface
REQ-001 Parameter WAIT_MAX, default 15, is the maximum number of mem_ready wait cycles before timeout (range 1..255).
REQ-002 Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; when 1, instructions are fetched and executed back to back.
REQ-005 instr_op  in  4  opcode field instruction[19:16] from the instruction register.
REQ-006 mem_ready  in  1  memory completion strobe for the current mem_req.
REQ-007 cond_zero  in  1  1 when the ALU result register equals 0; used by conditional copy.
REQ-008 mem_req, W  out  1 each  memory request; write strobe (store only).
REQ-009 ir_we, pc_inc, rf_we, alu_we, addr_we, dout_we  out  1 each  datapath register enables.
REQ-010 alu_op  out  2  ALU control: 00 add, 01 or, 10 and, 11 not.
REQ-011 mux_sel  out  3  datapath mux: 000 Rb, 001 Ra, 010 DataIn, 011 ALU reg, 100 PC.
REQ-012 rd1_src  out  1  0: read port 1 addresses instruction[11:8]; 1: instruction[15:12] (store data/address).
REQ-013 state  out  3  current FSM state encoding; instr_done  out  1  one-cycle retire pulse.
REQ-014 err_illegal, err_timeout  out  1 each  sticky error flags; retired  out  16  retired-instruction count.

Function
REQ-015 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, SDATA=4, MEM=5, WB=6; 7 is unreachable and SHALL go to IDLE.
REQ-016 All enables, mem_req and W SHALL be 0 in any state or cycle where not explicitly asserted below; mux_sel defaults 100, alu_op 00, rd1_src 0.
REQ-017 IDLE: next state FETCH when run=1, else remain IDLE.
REQ-018 FETCH: mem_req=1, mux_sel=100, addr_we=1 in the first FETCH cycle; on the cycle mem_ready=1: ir_we=1, pc_inc=1, go DECODE.
REQ-019 DECODE (exactly one cycle), decoded by instr_op: 0000-0011 go EXEC; 1101 (load) addr_we=1, mux_sel=001, go MEM; 1100 (store) rd1_src=1, addr_we=1, mux_sel=000, go SDATA; 1110, 1111, 1011 go WB.
REQ-020 DECODE with any other opcode SHALL set err_illegal, not touch any register, count as retired, and complete as in REQ-025.
REQ-021 EXEC (one cycle): alu_we=1, alu_op=instr_op[1:0], go WB.
REQ-022 SDATA (one cycle): rd1_src=1, mux_sel=001, dout_we=1, go MEM.
REQ-023 MEM: mem_req=1; store also W=1 and rd1_src=1; load on mem_ready=1 asserts rf_we=1 with mux_sel=010 and completes; store completes on mem_ready=1.
REQ-024 WB (one cycle): rf_we=1; mux_sel 011 for ALU ops, 001 for copy (1110), 010 for copy input (1111), 001 for conditional copy (1011) with rf_we = NOT cond_zero.
REQ-025 Completion: instr_done=1 for that cycle, retired increments by 1 (wraps 0xFFFF->0x0000), next state FETCH if run=1 else IDLE.
REQ-026 run deasserted mid-instruction SHALL NOT abort it; the instruction completes and the FSM then enters IDLE.
REQ-027 A 8-bit wait counter SHALL clear on entering FETCH or MEM and increment each cycle there with mem_ready=0; when it reaches WAIT_MAX with mem_ready still 0, err_timeout SHALL be set, mem_req dropped, no retire, and the FSM SHALL go to IDLE.
REQ-028 mem_ready in any state other than FETCH/MEM SHALL be ignored.
REQ-029 Error flags SHALL stay set until Reset; they SHALL NOT block further execution.
REQ-030 Minimum latency, zero-wait memory: ALU op 5 cycles (FETCH, DECODE, EXEC, WB + next FETCH start), i.e. FETCH-to-FETCH 4 cycles; load 3; store 4; copy 3.

Reset
REQ-031 Reset=0 SHALL immediately force state=IDLE, all outputs 0 (mux_sel 100), retired=0, wait counter=0, both error flags 0, including mid-instruction.
REQ-032 After Reset returns to 1, the first FETCH SHALL occur on the first rising edge where run=1.

Verification
REQ-033 run=1, mem_ready=1 always, opcode 0000 -> states 1,2,3,6,1; alu_we in EXEC with alu_op=00; rf_we with mux_sel=011 in WB; retired=1.
REQ-034 Store (1100), mem_ready delayed 3 cycles in MEM -> SDATA dout_we=1; W=1 and mem_req=1 for 4 MEM cycles; instr_done on the 4th; no rf_we.
REQ-035 Conditional copy with cond_zero=1 then cond_zero=0 -> rf_we=0 then rf_we=1 (mux_sel=001) in WB; retired increments both times.
REQ-036 Opcode 0100 -> err_illegal=1 after DECODE, no enables asserted, next state FETCH; err stays 1 across later valid instructions.
REQ-037 WAIT_MAX=15, mem_ready held 0 in FETCH -> err_timeout=1 after 15 wait cycles, state=IDLE, retired unchanged.
REQ-038 Reset asserted in MEM of a load, and retired preset to 0xFFFF then one more retire before reset -> retired wraps to 0x0000; on Reset all outputs 0 asynchronously, state=0.
